// File: rtl/pulse_stretch_driver.sv
// pulse_stretch_driver: turns single-cycle trig events into fixed-length
// active pulses on dout, each followed by a minimum inactive gap. Events that
// arrive while a pulse/gap is running are queued in a saturating counter.
//
// Ports:
//   clk       rising-edge clock
//   n_rst     asynchronous active-low reset
//   trig      event request, one event per cycle high
//   flush     synchronous clear of pending count and overflow flag
//   dout      registered output line (IDLE_VAL when inactive)
//   busy      high while a pulse or its gap is in progress
//   pending   queued events not yet started
//   overflow  sticky flag, set when an event is lost to saturation
module pulse_stretch_driver #(
  parameter int unsigned CLOCK_FREQ = 24000000,
  parameter int unsigned HOLD_MS    = 10,
  parameter int unsigned GAP_MS     = 10,
  parameter int unsigned PEND_WIDTH = 4,
  parameter logic        IDLE_VAL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  trig,
  input  logic                  flush,
  output logic                  dout,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow
);

  localparam int unsigned HOLD_CYCLES = (CLOCK_FREQ / 1000) * HOLD_MS;
  localparam int unsigned GAP_CYCLES  = (CLOCK_FREQ / 1000) * GAP_MS;
  localparam int unsigned MAX_CYCLES  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W       = $clog2(MAX_CYCLES) + 1;

  // Counters are loaded with duration-1 and the state moves on when they hit 0.
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = {PEND_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  dout_q, dout_d;
  logic                  busy_q, busy_d;
  logic                  deq;

  // Next-state, duration counter, event queue and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    deq     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Idle trigger starts the pulse directly; it never goes through the queue.
        if (trig && !flush) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LAST;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          // A flush on the final gap edge empties the queue, so nothing is dequeued.
          if (pend_q != '0 && !flush) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LAST;
            deq     = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pending queue: flush wins; a simultaneous enqueue and dequeue cancel.
    if (flush) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (trig && !deq) begin
        if (pend_q == PEND_MAX) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + PEND_WIDTH'(1);
        end
      end else if (!trig && deq) begin
        pend_d = pend_q - PEND_WIDTH'(1);
      end
    end

    dout_d = (state_d == ST_HOLD) ? ~IDLE_VAL : IDLE_VAL;
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= IDLE_VAL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule
